// File: rtl/serial_word_loader_pkg.sv
// Shared constants for the serial word loader: default word width and FSM state encodings.
package serial_word_loader_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/loader_bit_counter.sv
// Counts accepted data bits of one frame.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   clear         - synchronous clear to zero (takes priority over enable)
//   enable        - count one accepted bit on this edge
//   last_c        - combinational terminal count: the next accepted bit is the WIDTH-th
module loader_bit_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last_c
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] count;

    // Bit counter; the FSM leaves SHIFT on the terminal bit, so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign last_c = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_loader.sv
// Assembles an MSB-first serial frame of WIDTH data bits plus one even-parity bit
// into a parallel word, loading the output register only when parity checks out.
// Ports:
//   clock, reset         - rising-edge clock, asynchronous active-high reset
//   start                - begin a frame (honoured only when idle)
//   abort                - drop the frame in progress, no pulse
//   bit_valid, serial_in - qualified serial data / parity bit
//   word_out, word_out_n - last good word and its complement (registered)
//   word_valid           - one-cycle pulse when word_out was just loaded
//   parity_err           - one-cycle pulse when a frame failed parity
//   busy                 - high whenever the FSM is not idle
module serial_word_loader #(
    parameter int unsigned WIDTH = serial_word_loader_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_out,
    output logic [WIDTH-1:0] word_out_n,
    output logic             word_valid,
    output logic             parity_err,
    output logic             busy
);

    import serial_word_loader_pkg::state_e;
    import serial_word_loader_pkg::IDLE;
    import serial_word_loader_pkg::SHIFT;
    import serial_word_loader_pkg::PARITY;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_last_c;

    // Counter is held clear while idle; abort wins over a simultaneous bit.
    assign cnt_clear  = (state == IDLE);
    assign cnt_enable = (state == SHIFT) && bit_valid && !abort;

    loader_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last_c (cnt_last_c)
    );

    // Frame FSM, shift register and output word register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            word_out   <= '0;
            word_out_n <= '1;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= SHIFT;
                        shreg <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        shreg <= {shreg[WIDTH-2:0], serial_in};
                        if (cnt_last_c) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        // Even parity: the parity bit must equal the XOR of the data bits.
                        if (serial_in == ^shreg) begin
                            word_out   <= shreg;
                            word_out_n <= ~shreg;
                            word_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader with a pulse scoreboard.
module tb_serial_word_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        bit_valid;
    logic        serial_in;
    logic [31:0] word_out;
    logic [31:0] word_out_n;
    logic        word_valid;
    logic        parity_err;
    logic        busy;

    serial_word_loader #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .word_out   (word_out),
        .word_out_n (word_out_n),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_valid;   // 1: expect word_valid, 0: expect parity_err
        logic [31:0] word;       // word_out expected while the pulse is high
        int          cyc;        // expected edge number, 0 = don't care
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the next scoreboard entry.
    always @(negedge clock) begin
        if (reset !== 1'b1 && (word_valid === 1'b1 || parity_err === 1'b1)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: valid=%b err=%b word=%h at edge %0d",
                         word_valid, parity_err, word_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_valid", 32'(word_valid), 32'(e.is_valid));
                check("pulse_err", 32'(parity_err), 32'(!e.is_valid));
                check("word_out", word_out, e.word);
                check("word_out_n", word_out_n, ~e.word);
                if (e.cyc != 0) check("latency_edge", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        bit_valid = 1'b1;
        serial_in = b;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic is_valid, input logic [31:0] w, input int c);
        exp_t e;
        e.is_valid = is_valid;
        e.word     = w;
        e.cyc      = c;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic p, input int max_gap);
        do_start();
        for (int i = 31; i >= 0; i--) send_bit(w[i], max_gap);
        send_bit(p, max_gap);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
        // Reset state
        tick();
        check("rst_word_out", word_out, 32'h0000_0000);
        check("rst_word_out_n", word_out_n, 32'hFFFF_FFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_err", 32'(parity_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Bits in IDLE are ignored
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        check("idle_ignores_bits", 32'(busy), 32'd0);

        // abort with start in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);

        // 32 ones, parity 0, no gaps: pulse on edge 34 counting the start edge as edge 1
        push(1'b1, 32'hFFFF_FFFF, cyc + 34);
        do_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 32; i++) send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("busy_after_frame", 32'(busy), 32'd0);
        tick();

        // 0x00000001 parity 1 with random gaps
        push(1'b1, 32'h0000_0001, 0);
        send_frame(32'h0000_0001, 1'b1, 2);
        repeat (2) tick();

        // 0x00000001 parity 0: error, word held
        push(1'b0, 32'h0000_0001, 0);
        send_frame(32'h0000_0001, 1'b0, 1);
        repeat (2) tick();
        check("hold_after_err", word_out, 32'h0000_0001);

        // Abort after 10 bits, then a full A5A5A5A5 frame (16 ones -> parity 0)
        do_start();
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("busy_after_abort", 32'(busy), 32'd0);
        push(1'b1, 32'hA5A5_A5A5, 0);
        send_frame(32'hA5A5_A5A5, 1'b0, 0);
        tick();

        // Abort together with the parity bit drops the frame
        do_start();
        for (int i = 0; i < 32; i++) send_bit(1'b0, 0);
        abort = 1'b1; bit_valid = 1'b1; serial_in = 1'b0;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        check("abort_on_parity_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        check("abort_on_parity_word", word_out, 32'hA5A5_A5A5);

        // Reset after 20 bits, checked before the next edge
        do_start();
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_word_out", word_out, 32'h0000_0000);
        check("midrst_word_out_n", word_out_n, 32'hFFFF_FFFF);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("post_rst_needs_start", 32'(busy), 32'd0);

        // 0x12345678 (13 ones -> parity 1) with start pulsed on bit 6
        begin
            logic [31:0] w;
            w = 32'h1234_5678;
            push(1'b1, w, cyc + 34);
            do_start();
            for (int i = 31; i >= 0; i--) begin
                if (i == 26) start = 1'b1;
                send_bit(w[i], 0);
                start = 1'b0;
            end
            send_bit(1'b1, 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: expected valid=%b word=%h did not occur", e.is_valid, e.word);
        end
        check("final_word_out", word_out, 32'h1234_5678);
        check("final_word_out_n", word_out_n, 32'hEDCB_A987);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
